// File: rtl/rob_queue.sv
// Reorder buffer: circular queue of in-flight results, retired in program order.
// Allocates tags at issue, absorbs ALU/LSB broadcasts and flushes on a mispredicted branch.
module rob_queue #(
  parameter int ROB_SIZE_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rdy,
  output logic                      rob_full,
  output logic [ROB_SIZE_WIDTH-1:0] rob_tail_id,
  input  logic                      issue_valid,
  input  logic [1:0]                issue_type,
  input  logic [4:0]                issue_rd,
  input  logic                      issue_ready,
  input  logic [31:0]               issue_value,
  input  logic                      issue_pred,
  input  logic [31:0]               issue_alt_pc,
  input  logic                      rs_ready,
  input  logic [ROB_SIZE_WIDTH-1:0] rs_rob_id,
  input  logic [31:0]               rs_value,
  input  logic                      lsb_ready,
  input  logic [ROB_SIZE_WIDTH-1:0] lsb_rob_id,
  input  logic [31:0]               lsb_value,
  input  logic [ROB_SIZE_WIDTH-1:0] query_id1,
  input  logic [ROB_SIZE_WIDTH-1:0] query_id2,
  output logic                      query_rdy1,
  output logic                      query_rdy2,
  output logic [31:0]               query_val1,
  output logic [31:0]               query_val2,
  output logic                      commit_valid,
  output logic [1:0]                commit_type,
  output logic [4:0]                commit_rd,
  output logic [31:0]               commit_value,
  output logic [ROB_SIZE_WIDTH-1:0] commit_rob_id,
  output logic                      rob_clear,
  output logic [31:0]               clear_pc
);

  localparam int W = ROB_SIZE_WIDTH;
  localparam int N = 1 << W;

  logic [W-1:0] r_head;
  logic [W-1:0] r_tail;
  logic [W:0]   r_count;
  logic [N-1:0] r_busy;
  logic [N-1:0] r_ready;
  logic [N-1:0] r_pred;
  logic [1:0]   r_type   [N];
  logic [4:0]   r_rd     [N];
  logic [31:0]  r_value  [N];
  logic [31:0]  r_alt_pc [N];

  logic w_full;
  logic w_commit;
  logic w_flush;
  logic w_issue;
  logic w_rs_hit;
  logic w_lsb_hit;

  assign w_full    = (r_count == (W+1)'(N));
  assign w_commit  = r_busy[r_head] & r_ready[r_head];
  assign w_flush   = w_commit & (r_type[r_head] == 2'd1) &
                     (r_value[r_head][0] != r_pred[r_head]);
  assign w_issue   = issue_valid & ~w_full & ~w_flush;
  assign w_rs_hit  = rs_ready & r_busy[rs_rob_id] & ~w_flush;
  assign w_lsb_hit = lsb_ready & r_busy[lsb_rob_id] & ~w_flush;

  assign rob_full    = w_full;
  assign rob_tail_id = r_tail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_busy        <= '0;
      r_ready       <= '0;
      commit_valid  <= 1'b0;
      commit_type   <= '0;
      commit_rd     <= '0;
      commit_value  <= '0;
      commit_rob_id <= '0;
      rob_clear     <= 1'b0;
      clear_pc      <= '0;
    end else if (rdy) begin
      commit_valid <= w_commit;
      rob_clear    <= w_flush;
      if (w_commit) begin
        commit_type   <= r_type[r_head];
        commit_rd     <= r_rd[r_head];
        commit_value  <= r_value[r_head];
        commit_rob_id <= r_head;
      end
      if (w_flush) begin
        clear_pc <= r_alt_pc[r_head];
        r_head   <= '0;
        r_tail   <= '0;
        r_count  <= '0;
        r_busy   <= '0;
        r_ready  <= '0;
      end else begin
        // head and tail only coincide when empty or full, so these never collide
        if (w_commit) begin
          r_busy[r_head] <= 1'b0;
          r_head         <= r_head + 1'b1;
        end
        if (w_issue) begin
          r_busy[r_tail]  <= 1'b1;
          r_ready[r_tail] <= issue_ready;
          r_tail          <= r_tail + 1'b1;
        end
        if (w_rs_hit)  r_ready[rs_rob_id]  <= 1'b1;
        if (w_lsb_hit) r_ready[lsb_rob_id] <= 1'b1;
        r_count <= r_count + {{W{1'b0}}, w_issue} - {{W{1'b0}}, w_commit};
      end
    end else begin
      commit_valid <= 1'b0;
      rob_clear    <= 1'b0;
    end
  end

  // Payload needs no reset: busy/ready gate every use of it.
  always_ff @(posedge clk) begin
    if (rdy && !w_flush) begin
      if (w_issue) begin
        r_type[r_tail]   <= issue_type;
        r_rd[r_tail]     <= issue_rd;
        r_value[r_tail]  <= issue_value;
        r_pred[r_tail]   <= issue_pred;
        r_alt_pc[r_tail] <= issue_alt_pc;
      end
      if (w_rs_hit)  r_value[rs_rob_id]  <= rs_value;
      if (w_lsb_hit) r_value[lsb_rob_id] <= lsb_value;
    end
  end

  function automatic logic [32:0] f_query(input logic [W-1:0] id);
    logic [32:0] res;
    res = '0;
    if (lsb_ready && lsb_rob_id == id)      res = {1'b1, lsb_value};
    else if (rs_ready && rs_rob_id == id)   res = {1'b1, rs_value};
    else if (r_busy[id] && r_ready[id])     res = {1'b1, r_value[id]};
    return res;
  endfunction

  always_comb begin
    {query_rdy1, query_val1} = f_query(query_id1);
    {query_rdy2, query_val2} = f_query(query_id2);
  end

endmodule

// File: tb/tb_rob_queue.sv
// Bench for rob_queue: directed scenarios plus random traffic, all checked
// against an in-order queue model of the reorder buffer.
module tb_rob_queue;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst_n, rdy;
  logic         rob_full;
  logic [W-1:0] rob_tail_id;
  logic         issue_valid, issue_ready, issue_pred;
  logic [1:0]   issue_type;
  logic [4:0]   issue_rd;
  logic [31:0]  issue_value, issue_alt_pc;
  logic         rs_ready, lsb_ready;
  logic [W-1:0] rs_rob_id, lsb_rob_id, query_id1, query_id2;
  logic [31:0]  rs_value, lsb_value;
  logic         query_rdy1, query_rdy2;
  logic [31:0]  query_val1, query_val2;
  logic         commit_valid, rob_clear;
  logic [1:0]   commit_type;
  logic [4:0]   commit_rd;
  logic [31:0]  commit_value, clear_pc;
  logic [W-1:0] commit_rob_id;

  always #5 clk = ~clk;

  rob_queue #(.ROB_SIZE_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .rob_full(rob_full), .rob_tail_id(rob_tail_id),
    .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
    .issue_ready(issue_ready), .issue_value(issue_value), .issue_pred(issue_pred),
    .issue_alt_pc(issue_alt_pc),
    .rs_ready(rs_ready), .rs_rob_id(rs_rob_id), .rs_value(rs_value),
    .lsb_ready(lsb_ready), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value),
    .query_id1(query_id1), .query_id2(query_id2),
    .query_rdy1(query_rdy1), .query_rdy2(query_rdy2),
    .query_val1(query_val1), .query_val2(query_val2),
    .commit_valid(commit_valid), .commit_type(commit_type), .commit_rd(commit_rd),
    .commit_value(commit_value), .commit_rob_id(commit_rob_id),
    .rob_clear(rob_clear), .clear_pc(clear_pc)
  );

  typedef struct {
    logic [W-1:0] tag;
    logic [1:0]   typ;
    logic [4:0]   rd;
    logic         rdy;
    logic [31:0]  val;
    logic         pred;
    logic [31:0]  alt;
  } ent_t;

  ent_t         mq[$];
  logic [W-1:0] m_tail = '0;
  logic         exp_cv, exp_clr;
  logic [1:0]   exp_ct;
  logic [4:0]   exp_crd;
  logic [31:0]  exp_cval, exp_cpc;
  logic [W-1:0] exp_cid;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  function automatic logic [32:0] mquery(input logic [W-1:0] id);
    if (lsb_ready && lsb_rob_id == id) return {1'b1, lsb_value};
    if (rs_ready && rs_rob_id == id) return {1'b1, rs_value};
    foreach (mq[i]) if (mq[i].tag == id && mq[i].rdy) return {1'b1, mq[i].val};
    return 33'd0;
  endfunction

  // Model of one clock edge: oldest-first commit, broadcasts, then allocation.
  task automatic model_edge();
    bit   committing, flush, was_full;
    ent_t e;
    exp_cv  = 1'b0;
    exp_clr = 1'b0;
    if (!rdy) return;
    was_full   = (mq.size() == 8);
    committing = (mq.size() > 0) && mq[0].rdy;
    flush      = 1'b0;
    if (committing) begin
      exp_ct   = mq[0].typ;
      exp_crd  = mq[0].rd;
      exp_cval = mq[0].val;
      exp_cid  = mq[0].tag;
      flush    = (mq[0].typ == 2'd1) && (mq[0].val[0] != mq[0].pred);
      if (flush) exp_cpc = mq[0].alt;
    end
    exp_cv  = committing;
    exp_clr = flush;
    if (flush) begin
      mq.delete();
      m_tail = '0;
      return;
    end
    foreach (mq[i]) begin
      if (rs_ready && mq[i].tag == rs_rob_id) begin mq[i].rdy = 1'b1; mq[i].val = rs_value; end
      if (lsb_ready && mq[i].tag == lsb_rob_id) begin mq[i].rdy = 1'b1; mq[i].val = lsb_value; end
    end
    if (committing) void'(mq.pop_front());
    if (issue_valid && !was_full) begin
      e.tag = m_tail; e.typ = issue_type; e.rd = issue_rd; e.rdy = issue_ready;
      e.val = issue_value; e.pred = issue_pred; e.alt = issue_alt_pc;
      mq.push_back(e);
      m_tail = m_tail + 1'b1;
    end
  endtask

  // Called 1 time unit after a posedge with inputs already driven.
  task automatic step();
    logic [32:0] q;
    #2;
    q = mquery(query_id1);
    chk("q1_rdy", {31'd0, query_rdy1}, {31'd0, q[32]});
    chk("q1_val", query_val1, q[31:0]);
    q = mquery(query_id2);
    chk("q2_rdy", {31'd0, query_rdy2}, {31'd0, q[32]});
    chk("q2_val", query_val2, q[31:0]);
    model_edge();
    @(posedge clk);
    #1;
    chk("commit_valid", {31'd0, commit_valid}, {31'd0, exp_cv});
    if (exp_cv) begin
      chk("commit_type", {30'd0, commit_type}, {30'd0, exp_ct});
      chk("commit_rd", {27'd0, commit_rd}, {27'd0, exp_crd});
      chk("commit_value", commit_value, exp_cval);
      chk("commit_rob_id", {29'd0, commit_rob_id}, {29'd0, exp_cid});
    end
    chk("rob_clear", {31'd0, rob_clear}, {31'd0, exp_clr});
    if (exp_clr) chk("clear_pc", clear_pc, exp_cpc);
    chk("rob_full", {31'd0, rob_full}, {31'd0, mq.size() == 8});
    chk("rob_tail_id", {29'd0, rob_tail_id}, {29'd0, m_tail});
  endtask

  task automatic idle();
    rdy = 1'b1; issue_valid = 1'b0; issue_type = 2'd0; issue_rd = 5'd0;
    issue_ready = 1'b0; issue_value = 32'd0; issue_pred = 1'b0; issue_alt_pc = 32'd0;
    rs_ready = 1'b0; rs_rob_id = '0; rs_value = 32'd0;
    lsb_ready = 1'b0; lsb_rob_id = '0; lsb_value = 32'd0;
    query_id1 = '0; query_id2 = '0;
  endtask

  task automatic issue1(input logic [1:0] t, input logic [4:0] rd, input logic r,
                        input logic [31:0] v, input logic p, input logic [31:0] a);
    idle();
    issue_valid = 1'b1; issue_type = t; issue_rd = rd; issue_ready = r;
    issue_value = v; issue_pred = p; issue_alt_pc = a;
    step();
  endtask

  task automatic wb_rs(input logic [W-1:0] tag, input logic [31:0] v);
    idle();
    rs_ready = 1'b1; rs_rob_id = tag; rs_value = v;
    step();
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && mq.size() > 0; k++) begin
      idle();
      foreach (mq[i]) begin
        if (!mq[i].rdy) begin
          rs_ready = 1'b1; rs_rob_id = mq[i].tag; rs_value = $urandom;
          break;
        end
      end
      step();
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_full"}, {31'd0, rob_full}, 32'd0);
    chk({tag, "_tail"}, {29'd0, rob_tail_id}, 32'd0);
    chk({tag, "_cvalid"}, {31'd0, commit_valid}, 32'd0);
    chk({tag, "_ctype"}, {30'd0, commit_type}, 32'd0);
    chk({tag, "_crd"}, {27'd0, commit_rd}, 32'd0);
    chk({tag, "_cval"}, commit_value, 32'd0);
    chk({tag, "_cid"}, {29'd0, commit_rob_id}, 32'd0);
    chk({tag, "_clear"}, {31'd0, rob_clear}, 32'd0);
    chk({tag, "_cpc"}, clear_pc, 32'd0);
  endtask

  task automatic rand_inputs();
    int r;
    idle();
    rdy = ($urandom_range(0, 9) != 0);
    issue_valid = ($urandom_range(0, 99) < 55);
    r = $urandom_range(0, 9);
    issue_type = (r < 6) ? 2'd0 : (r == 6) ? 2'd1 : (r == 7) ? 2'd2 : 2'd3;
    issue_rd = 5'($urandom);
    issue_ready = ($urandom_range(0, 9) < 3);
    issue_value = $urandom;
    issue_pred = 1'($urandom);
    issue_alt_pc = $urandom;
    if (mq.size() > 0 && $urandom_range(0, 9) < 6) begin
      rs_ready = 1'b1; rs_rob_id = mq[$urandom_range(0, mq.size() - 1)].tag;
    end else begin
      rs_ready = ($urandom_range(0, 9) == 0); rs_rob_id = W'($urandom);
    end
    rs_value = $urandom;
    if (mq.size() > 0 && $urandom_range(0, 9) < 4) begin
      lsb_ready = 1'b1; lsb_rob_id = mq[$urandom_range(0, mq.size() - 1)].tag;
    end else begin
      lsb_ready = ($urandom_range(0, 9) == 0); lsb_rob_id = W'($urandom);
    end
    if ($urandom_range(0, 9) == 0) lsb_rob_id = rs_rob_id;
    lsb_value = $urandom;
    query_id1 = (mq.size() > 0 && $urandom_range(0, 1) == 1) ? mq[0].tag : W'($urandom);
    query_id2 = W'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] btag;
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("por");
    rst_n = 1'b1;

    // Out-of-order writeback, in-order commit
    issue1(2'd0, 5'd1, 1'b0, 32'd0, 1'b0, 32'd0);
    issue1(2'd0, 5'd2, 1'b0, 32'd0, 1'b0, 32'd0);
    issue1(2'd0, 5'd3, 1'b0, 32'd0, 1'b0, 32'd0);
    wb_rs(3'd1, 32'h55);
    chk("t2_wait_head", {31'd0, commit_valid}, 32'd0);
    wb_rs(3'd0, 32'h11);
    chk("t2_no_early", {31'd0, commit_valid}, 32'd0);
    idle(); step();
    chk("t2_c0_valid", {31'd0, commit_valid}, 32'd1);
    chk("t2_c0_rd", {27'd0, commit_rd}, 32'd1);
    chk("t2_c0_val", commit_value, 32'h11);
    idle(); step();
    chk("t2_c1_rd", {27'd0, commit_rd}, 32'd2);
    chk("t2_c1_val", commit_value, 32'h55);
    idle(); step();
    chk("t2_tag2_waits", {31'd0, commit_valid}, 32'd0);

    // Reset in the middle of traffic with several entries busy
    for (int i = 0; i < 4; i++) issue1(2'd0, 5'(i + 4), 1'b0, 32'd0, 1'b0, 32'd0);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    mq.delete();
    m_tail = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(); step();
    chk("rst_tail_after", {29'd0, rob_tail_id}, 32'd0);

    // Fill to capacity, overflow attempt, commit while full
    for (int i = 0; i < 8; i++) issue1(2'd0, 5'(i + 8), 1'b0, 32'd0, 1'b0, 32'd0);
    chk("t3_full", {31'd0, rob_full}, 32'd1);
    chk("t3_tail_wrap", {29'd0, rob_tail_id}, 32'd0);
    issue1(2'd0, 5'd31, 1'b1, 32'hDEAD, 1'b0, 32'd0);
    chk("t3_9th_ignored", {29'd0, rob_tail_id}, 32'd0);
    wb_rs(3'd0, 32'hC0DE);
    issue1(2'd0, 5'd30, 1'b1, 32'hBEEF, 1'b0, 32'd0);
    chk("t3_commit_tag0", {31'd0, commit_valid}, 32'd1);
    chk("t3_not_full", {31'd0, rob_full}, 32'd0);
    chk("t3_issue_blocked", {29'd0, rob_tail_id}, 32'd0);
    drain();

    // Mispredicted branch flushes younger entries
    btag = m_tail;
    issue1(2'd1, 5'd0, 1'b0, 32'd0, 1'b0, 32'h1000);
    for (int i = 0; i < 3; i++) issue1(2'd0, 5'(i + 20), 1'b1, 32'(i + 100), 1'b0, 32'd0);
    wb_rs(btag, 32'd1);
    idle(); issue_valid = 1'b1; issue_rd = 5'd9; issue_ready = 1'b1;
    step();
    chk("t4_cvalid", {31'd0, commit_valid}, 32'd1);
    chk("t4_ctype", {30'd0, commit_type}, 32'd1);
    chk("t4_clear", {31'd0, rob_clear}, 32'd1);
    chk("t4_clear_pc", clear_pc, 32'h1000);
    chk("t4_tail", {29'd0, rob_tail_id}, 32'd0);
    idle(); step();
    chk("t4_no_commit", {31'd0, commit_valid}, 32'd0);
    chk("t4_clear_drop", {31'd0, rob_clear}, 32'd0);
    idle(); step();
    chk("t4_still_quiet", {31'd0, commit_valid}, 32'd0);

    // Same-tag broadcasts on both buses: LSB value wins
    for (int i = 0; i < 3; i++) issue1(2'd0, 5'(i + 1), 1'b0, 32'd0, 1'b0, 32'd0);
    idle();
    rs_ready = 1'b1; rs_rob_id = 3'd2; rs_value = 32'hA;
    lsb_ready = 1'b1; lsb_rob_id = 3'd2; lsb_value = 32'hB;
    query_id1 = 3'd2;
    #2;
    chk("t5_bypass_val", query_val1, 32'hB);
    step();
    idle(); query_id1 = 3'd2;
    #2;
    chk("t5_stored_val", query_val1, 32'hB);
    step();
    drain();

    // Stall with a committable head
    issue1(2'd0, 5'd7, 1'b1, 32'h77, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      idle(); rdy = 1'b0; step();
      chk("t6_stalled", {31'd0, commit_valid}, 32'd0);
    end
    idle(); step();
    chk("t6_pulse", {31'd0, commit_valid}, 32'd1);
    chk("t6_val", commit_value, 32'h77);
    idle(); step();
    chk("t6_single", {31'd0, commit_valid}, 32'd0);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      rand_inputs();
      step();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
